// File: rtl/arm_exe_hazard_unit.sv
// -----------------------------------------------------------------------------
// arm_exe_hazard_unit
//
// Execute slice of the five-stage ARM pipeline. This block does four jobs:
//   * It builds operand 2 (Val2) from the shifter field.
//   * It runs the ALU and produces new N/Z/C/V flags.
//   * It computes the branch target.
//   * It latches the results into the EX/MEM pipeline register.
// It also raises a stall request whenever the instruction in decode reads a
// register that an in-flight instruction will write. There is no forwarding.
//
// Optional feature (compile-time macro EXE_DEBUG_TRACE_EN):
//   defined   : pc_out / instruction_out are registered copies of
//               pc_in / instruction_in.
//   undefined : both outputs are tied to 0 and have no flops behind them.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous, active-low reset (registered outputs only)
//   pc_in             PC+4 of the EXE instruction
//   instruction_in    EXE instruction word (debug trace only)
//   signed_immediate  branch offset in words
//   EX_command        ALU opcode
//   SR_in             current flags {N,Z,C,V}
//   shifter_operand   operand-2 field
//   imm               operand 2 is a rotated 8-bit immediate
//   dst_in            destination register of the EXE instruction
//   mem_read_in       EXE instruction is a load
//   mem_write_in      EXE instruction is a store
//   WB_en_in          EXE instruction writes back
//   B_in              EXE instruction is a taken branch
//   val_Rn_in         first register operand
//   val_Rm_in         second register operand
//   rn, rdm           source registers of the decode instruction
//   twoSrc            decode instruction also reads rdm
//   SR_out            new flags (combinational)
//   branch_address    branch target (combinational)
//   B_out             copy of B_in (combinational)
//   hazard            stall request for decode (combinational)
//   dst_out, ALU_res_out, val_Rm_out, mem_read_out, mem_write_out,
//   WB_en_out, pc_out, instruction_out : EX/MEM register fields
// -----------------------------------------------------------------------------
module arm_exe_hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction_in,
  input  logic [23:0] signed_immediate,
  input  logic [3:0]  EX_command,
  input  logic [3:0]  SR_in,
  input  logic [11:0] shifter_operand,
  input  logic        imm,
  input  logic [3:0]  dst_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        WB_en_in,
  input  logic        B_in,
  input  logic [31:0] val_Rn_in,
  input  logic [31:0] val_Rm_in,
  input  logic [3:0]  rn,
  input  logic [3:0]  rdm,
  input  logic        twoSrc,
  output logic [3:0]  SR_out,
  output logic [31:0] branch_address,
  output logic        B_out,
  output logic        hazard,
  output logic [3:0]  dst_out,
  output logic [31:0] ALU_res_out,
  output logic [31:0] val_Rm_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        WB_en_out,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out
);

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Rotate right. Shifting the doubled word handles r == 0 without a
  // shift-by-32 special case.
  function automatic logic [31:0] ror32(input logic [31:0] x,
                                        input logic [4:0]  r);
    logic [63:0] dbl;
    dbl = {x, x} >> r;
    return dbl[31:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Operand 2 (Val2)
  // ---------------------------------------------------------------------------
  logic        [31:0] val2;
  logic        [4:0]  rot_amt;
  logic        [4:0]  sh_amt;
  logic signed [31:0] rm_s;

  assign rot_amt = {shifter_operand[11:8], 1'b0};
  assign sh_amt  = shifter_operand[11:7];
  assign rm_s    = val_Rm_in;

  always_comb begin
    val2 = '0;
    if (imm) begin
      val2 = ror32({24'h0, shifter_operand[7:0]}, rot_amt);
    end else if (mem_read_in || mem_write_in) begin
      // Loads and stores use the raw 12-bit offset, zero-extended.
      val2 = {20'h0, shifter_operand};
    end else begin
      unique case (shifter_operand[6:5])
        SH_LSL:  val2 = val_Rm_in << sh_amt;
        SH_LSR:  val2 = val_Rm_in >> sh_amt;
        SH_ASR:  val2 = $unsigned(rm_s >>> sh_amt);
        SH_ROR:  val2 = ror32(val_Rm_in, sh_amt);
        default: val2 = val_Rm_in;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ALU and flags
  // ---------------------------------------------------------------------------
  // Add and subtract share one 33-bit adder. A subtraction is done as
  // A + ~B + cin. With that form, the carry out is exactly ARM's NOT-borrow,
  // and the overflow check is the same for both directions when it is taken
  // against the inverted operand.
  logic        [31:0] arith_b;
  logic               arith_cin;
  logic               arith_sel;
  logic        [32:0] arith_sum;
  logic               arith_v;
  logic        [31:0] alu_res_d;
  logic               op_valid;
  logic               flag_c;
  logic               flag_v;

  always_comb begin
    arith_b   = val2;
    arith_cin = 1'b0;
    arith_sel = 1'b0;
    unique case (EX_command)
      OP_ADD: begin arith_sel = 1'b1; end
      OP_ADC: begin arith_sel = 1'b1; arith_cin = SR_in[1]; end
      OP_SUB: begin arith_sel = 1'b1; arith_b = ~val2; arith_cin = 1'b1; end
      OP_SBC: begin arith_sel = 1'b1; arith_b = ~val2; arith_cin = SR_in[1]; end
      default: ;
    endcase
  end

  assign arith_sum = {1'b0, val_Rn_in} + {1'b0, arith_b} + {32'h0, arith_cin};
  assign arith_v   = (val_Rn_in[31] == arith_b[31]) &&
                     (arith_sum[31] != val_Rn_in[31]);

  always_comb begin
    alu_res_d = '0;
    op_valid  = 1'b1;
    unique case (EX_command)
      OP_MOV:                         alu_res_d = val2;
      OP_MVN:                         alu_res_d = ~val2;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: alu_res_d = arith_sum[31:0];
      OP_AND:                         alu_res_d = val_Rn_in & val2;
      OP_ORR:                         alu_res_d = val_Rn_in | val2;
      OP_EOR:                         alu_res_d = val_Rn_in ^ val2;
      default:                        op_valid  = 1'b0;
    endcase
  end

  // Logical ops and moves keep C and V from the incoming status register.
  assign flag_c = arith_sel ? arith_sum[32] : SR_in[1];
  assign flag_v = arith_sel ? arith_v       : SR_in[0];

  // Unknown opcodes pass the flags through untouched.
  assign SR_out = op_valid ? {alu_res_d[31], (alu_res_d == 32'h0), flag_c, flag_v}
                           : SR_in;

  // ---------------------------------------------------------------------------
  // Branch target
  // ---------------------------------------------------------------------------
  logic [31:0] br_offset;

  assign br_offset      = {{6{signed_immediate[23]}}, signed_immediate, 2'b00};
  assign branch_address = pc_in + br_offset;
  assign B_out          = B_in;

  // ---------------------------------------------------------------------------
  // RAW hazard detection
  // ---------------------------------------------------------------------------
  // There is no forwarding path, so any pending write to a source register
  // stalls decode. Both pipeline slots are checked: the one in EXE, and the one
  // already sitting in EX/MEM. Register 0 gets no special treatment.
  logic rn_hit;
  logic rdm_hit;

  assign rn_hit  = (WB_en_in  && (rn  == dst_in)) ||
                   (WB_en_out && (rn  == dst_out));
  assign rdm_hit = (WB_en_in  && (rdm == dst_in)) ||
                   (WB_en_out && (rdm == dst_out));
  assign hazard  = rn_hit || (twoSrc && rdm_hit);

  // ---------------------------------------------------------------------------
  // EX/MEM register
  // ---------------------------------------------------------------------------
  logic [3:0]  dst_q;
  logic [31:0] alu_res_q;
  logic [31:0] val_rm_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        wb_en_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dst_q       <= '0;
      alu_res_q   <= '0;
      val_rm_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wb_en_q     <= 1'b0;
    end else begin
      dst_q       <= dst_in;
      alu_res_q   <= alu_res_d;
      val_rm_q    <= val_Rm_in;
      mem_read_q  <= mem_read_in;
      mem_write_q <= mem_write_in;
      wb_en_q     <= WB_en_in;
    end
  end

  assign dst_out       = dst_q;
  assign ALU_res_out   = alu_res_q;
  assign val_Rm_out    = val_rm_q;
  assign mem_read_out  = mem_read_q;
  assign mem_write_out = mem_write_q;
  assign WB_en_out     = wb_en_q;

`ifdef EXE_DEBUG_TRACE_EN
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_in;
      instr_q <= instruction_in;
    end
  end

  assign pc_out          = pc_q;
  assign instruction_out = instr_q;
`else
  // Without the debug trace, the instruction word has no consumer.
  logic unused_trace;
  assign unused_trace    = ^instruction_in;
  assign pc_out          = 32'h0;
  assign instruction_out = 32'h0;
`endif

  // Bit 4 selects register-specified shifts, which this datapath does not
  // implement, so that bit is ignored.
  logic unused_so;
  assign unused_so = shifter_operand[4];

endmodule

// File: tb/tb_arm_exe_hazard_unit.sv
module tb_arm_exe_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, instruction_in;
  logic [23:0] signed_immediate;
  logic [3:0]  EX_command, SR_in;
  logic [11:0] shifter_operand;
  logic        imm;
  logic [3:0]  dst_in;
  logic        mem_read_in, mem_write_in, WB_en_in, B_in;
  logic [31:0] val_Rn_in, val_Rm_in;
  logic [3:0]  rn, rdm;
  logic        twoSrc;
  logic [3:0]  SR_out;
  logic [31:0] branch_address;
  logic        B_out, hazard;
  logic [3:0]  dst_out;
  logic [31:0] ALU_res_out, val_Rm_out;
  logic        mem_read_out, mem_write_out, WB_en_out;
  logic [31:0] pc_out, instruction_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  arm_exe_hazard_unit dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instruction_in(instruction_in),
    .signed_immediate(signed_immediate), .EX_command(EX_command), .SR_in(SR_in),
    .shifter_operand(shifter_operand), .imm(imm), .dst_in(dst_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .WB_en_in(WB_en_in),
    .B_in(B_in), .val_Rn_in(val_Rn_in), .val_Rm_in(val_Rm_in), .rn(rn), .rdm(rdm),
    .twoSrc(twoSrc), .SR_out(SR_out), .branch_address(branch_address), .B_out(B_out),
    .hazard(hazard), .dst_out(dst_out), .ALU_res_out(ALU_res_out),
    .val_Rm_out(val_Rm_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .WB_en_out(WB_en_out), .pc_out(pc_out),
    .instruction_out(instruction_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Operand 2 built one bit-step at a time from the shift description.
  function automatic logic [31:0] m_val2(input logic im, input logic mr, input logic mw,
                                         input logic [11:0] so, input logic [31:0] rm);
    logic [31:0] x;
    int n;
    if (im) begin
      x = {24'h0, so[7:0]};
      n = int'(so[11:8]) * 2;
      for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
    end else if (mr || mw) begin
      x = {20'h0, so};
    end else begin
      x = rm;
      n = int'(so[11:7]);
      for (int i = 0; i < n; i++) begin
        case (so[6:5])
          2'd0:    x = {x[30:0], 1'b0};
          2'd1:    x = {1'b0, x[31:1]};
          2'd2:    x = {x[31], x[31:1]};
          default: x = {x[0], x[31:1]};
        endcase
      end
    end
    return x;
  endfunction

  // Returns {flags, result}; carries and overflow derived with wide integers.
  function automatic logic [35:0] m_alu(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] sr);
    longint sa, sb, s;
    logic [63:0] ua, ub, k;
    logic [31:0] res;
    logic c, v, valid;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    c = sr[1]; v = sr[0]; valid = 1'b1; res = 32'h0;
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd2, 4'd3: begin
        k   = (cmd == 4'd3) ? {63'h0, sr[1]} : 64'h0;
        res = a + b + k[31:0];
        c   = (ua + ub + k) > 64'hFFFF_FFFF;
        s   = sa + sb + longint'(k);
        v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        k   = (cmd == 4'd5) ? {63'h0, !sr[1]} : 64'h0;
        res = a - b - k[31:0];
        c   = ua >= (ub + k);
        s   = sa - sb - longint'(k);
        v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      default: valid = 1'b0;
    endcase
    return {(valid ? {res[31], res == 32'h0, c, v} : sr), res};
  endfunction

  logic [35:0] m_now;
  logic [31:0] m_br;
  logic        m_haz;
  logic [31:0] m_res_q, m_rm_q, m_pc_q, m_ins_q;
  logic [3:0]  m_dst_q;
  logic        m_mr_q, m_mw_q, m_wb_q;

  always_comb begin
    m_now = m_alu(EX_command, val_Rn_in,
                  m_val2(imm, mem_read_in, mem_write_in, shifter_operand, val_Rm_in), SR_in);
    m_br  = pc_in + 32'(int'($signed(signed_immediate)) * 4);
    m_haz = (WB_en_in && rn == dst_in) || (m_wb_q && rn == m_dst_q) ||
            (twoSrc && ((WB_en_in && rdm == dst_in) || (m_wb_q && rdm == m_dst_q)));
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_res_q <= '0; m_rm_q <= '0; m_dst_q <= '0; m_mr_q <= 1'b0; m_mw_q <= 1'b0;
      m_wb_q <= 1'b0; m_pc_q <= '0; m_ins_q <= '0;
    end else begin
      m_res_q <= m_now[31:0]; m_rm_q <= val_Rm_in; m_dst_q <= dst_in;
      m_mr_q <= mem_read_in; m_mw_q <= mem_write_in; m_wb_q <= WB_en_in;
`ifdef EXE_DEBUG_TRACE_EN
      m_pc_q <= pc_in; m_ins_q <= instruction_in;
`else
      m_pc_q <= '0; m_ins_q <= '0;
`endif
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("SR_out", {28'h0, SR_out}, {28'h0, m_now[35:32]});
      chk("branch_address", branch_address, m_br);
      chk("B_out", {31'h0, B_out}, {31'h0, B_in});
      chk("hazard", {31'h0, hazard}, {31'h0, m_haz});
      chk("ALU_res_out", ALU_res_out, m_res_q);
      chk("val_Rm_out", val_Rm_out, m_rm_q);
      chk("dst_out", {28'h0, dst_out}, {28'h0, m_dst_q});
      chk("mem_read_out", {31'h0, mem_read_out}, {31'h0, m_mr_q});
      chk("mem_write_out", {31'h0, mem_write_out}, {31'h0, m_mw_q});
      chk("WB_en_out", {31'h0, WB_en_out}, {31'h0, m_wb_q});
      chk("pc_out", pc_out, m_pc_q);
      chk("instruction_out", instruction_out, m_ins_q);
    end
  end

  task automatic defaults();
    rst = 1'b1; pc_in = '0; instruction_in = '0; signed_immediate = '0;
    EX_command = '0; SR_in = '0; shifter_operand = '0; imm = 1'b0; dst_in = '0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; WB_en_in = 1'b0; B_in = 1'b0;
    val_Rn_in = '0; val_Rm_in = '0; rn = '0; rdm = '0; twoSrc = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    defaults();
    rst = 1'b0;
    tick();
    started = 1'b1;
    chk("reset_alu", ALU_res_out, 32'h0);
    chk("reset_wb", {31'h0, WB_en_out}, 32'h0);
    chk("reset_dst", {28'h0, dst_out}, 32'h0);
    tick();

    // MOV of rotated immediate 0xFF ror 4
    defaults(); imm = 1'b1; shifter_operand = 12'h2FF; EX_command = 4'b0001;
    #1 chk("mov_nz", {30'h0, SR_out[3:2]}, 32'h2);
    tick(); chk("mov_res", ALU_res_out, 32'hF000_000F);

    // SUB 5 - 5 via LSL #0
    defaults(); val_Rn_in = 32'd5; val_Rm_in = 32'd5; EX_command = 4'b0100;
    #1 chk("sub_flags", {28'h0, SR_out}, 32'h6);
    tick(); chk("sub_res", ALU_res_out, 32'h0);

    // ADD signed overflow
    defaults(); val_Rn_in = 32'h7FFF_FFFF; val_Rm_in = 32'd1; EX_command = 4'b0010;
    #1 chk("add_flags", {28'h0, SR_out}, 32'h9);
    tick(); chk("add_res", ALU_res_out, 32'h8000_0000);

    // Backward branch
    defaults(); pc_in = 32'h100; signed_immediate = 24'hFFFFFE; B_in = 1'b1;
    #1 chk("branch_lit", branch_address, 32'hF8);
    chk("b_out_lit", {31'h0, B_out}, 32'h1);

    // Hazard cases
    tick();
    defaults(); WB_en_in = 1'b1; dst_in = 4'd3; rn = 4'd3;
    #1 chk("haz_rn", {31'h0, hazard}, 32'h1);
    rn = 4'd5; rdm = 4'd3; twoSrc = 1'b0;
    #1 chk("haz_rdm_one_src", {31'h0, hazard}, 32'h0);
    twoSrc = 1'b1;
    #1 chk("haz_rdm_two_src", {31'h0, hazard}, 32'h1);
    tick();
    chk("wb_out_set", {31'h0, WB_en_out}, 32'h1);
    chk("dst_out_set", {28'h0, dst_out}, 32'h3);
    WB_en_in = 1'b0; rn = 4'd3; twoSrc = 1'b0;
    #1 chk("haz_mem_stage", {31'h0, hazard}, 32'h1);

    // Reset mid-stream overrides capture
    tick();
    defaults(); val_Rn_in = 32'd1; val_Rm_in = 32'd1; EX_command = 4'b0010;
    WB_en_in = 1'b1; dst_in = 4'd7; mem_write_in = 1'b1; rst = 1'b0;
    tick();
    chk("rst_alu", ALU_res_out, 32'h0);
    chk("rst_wb", {31'h0, WB_en_out}, 32'h0);
    chk("rst_rm", val_Rm_out, 32'h0);
    chk("rst_mw", {31'h0, mem_write_out}, 32'h0);
    rn = 4'd7;
    #1 chk("rst_haz_dst_in", {31'h0, hazard}, 32'h1);
    rn = 4'd0;
    #1 chk("rst_haz_reg_inactive", {31'h0, hazard}, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst              = ($urandom_range(0, 19) != 0);
      pc_in            = $urandom;
      instruction_in   = $urandom;
      signed_immediate = 24'($urandom);
      EX_command       = 4'($urandom);
      SR_in            = 4'($urandom);
      shifter_operand  = 12'($urandom);
      imm              = ($urandom_range(0, 2) == 0);
      dst_in           = 4'($urandom_range(0, 7));
      mem_read_in      = ($urandom_range(0, 5) == 0);
      mem_write_in     = ($urandom_range(0, 5) == 0);
      WB_en_in         = 1'($urandom);
      B_in             = 1'($urandom);
      val_Rn_in        = pick32();
      val_Rm_in        = pick32();
      rn               = 4'($urandom_range(0, 7));
      rdm              = 4'($urandom_range(0, 7));
      twoSrc           = 1'($urandom);
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
